// File: rtl/gardner_ted_iq.sv
// Complex Gardner timing-error detector: e = Re{(x[n-SPS] - x[n]) * conj(x[n-SPS/2])},
// three-stage pipeline with round/shift/saturate and a held valid/ready output.
module gardner_ted_iq #(
    parameter int SamplesPerSymbol = 4,
    parameter int InputLengthBits  = 12,
    parameter int OutputLengthBits = 16,
    parameter int ShiftBits        = 9,
    parameter int ModeIq           = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [InputLengthBits-1:0]  in_i,
    input  logic [InputLengthBits-1:0]  in_q,
    input  logic                        in_valid,
    input  logic                        trigger,
    output logic [OutputLengthBits-1:0] out,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        clear,
    output logic                        sat,
    output logic                        overrun,
    output logic [7:0]                  overrun_count
);

    localparam int SPS = SamplesPerSymbol;
    localparam int W   = InputLengthBits;
    localparam int OL  = OutputLengthBits;
    localparam int PW  = 2 * W + 2;
    localparam int XW  = ((PW + 1 > OL) ? PW + 1 : OL) + 1;

    localparam logic signed [XW-1:0] RND     = (XW'(1) << ShiftBits) >> 1;
    localparam logic signed [XW-1:0] SAT_MAX = {{(XW-OL+1){1'b0}}, {(OL-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OL-1:0]        OUT_MAX = {1'b0, {(OL-1){1'b1}}};
    localparam logic [OL-1:0]        OUT_MIN = {1'b1, {(OL-1){1'b0}}};

    if (SPS < 2 || (SPS % 2) != 0) begin : g_bad_sps
        $error("gardner_ted_iq: SamplesPerSymbol must be even and >= 2");
    end
    if (ShiftBits < 0 || ShiftBits > 2 * W + 1) begin : g_bad_shift
        $error("gardner_ted_iq: ShiftBits out of range 0..2W+1");
    end

    logic signed [W-1:0]   x_i, x_q;
    logic signed [W-1:0]   hist_i [SPS];
    logic signed [W-1:0]   hist_q [SPS];
    logic                  launch;
    logic                  v1, v2;
    logic signed [W:0]     d1_i, d1_q;
    logic signed [W-1:0]   m1_i, m1_q;
    logic signed [PW-1:0]  prod_i, prod_q, prod;
    logic signed [PW-1:0]  p2;
    logic signed [XW-1:0]  rnd;
    logic [OL-1:0]         res;
    logic                  clamp;
    logic                  ovr_evt;

    assign x_i    = in_i;
    assign x_q    = in_q;
    assign launch = in_valid & trigger;

    // hist[0] is x[n-1], hist[SPS-1] is x[n-SPS]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < SPS; k++) begin
                hist_i[k] <= '0;
                hist_q[k] <= '0;
            end
        end else if (in_valid) begin
            hist_i[0] <= x_i;
            hist_q[0] <= x_q;
            for (int unsigned k = 1; k < SPS; k++) begin
                hist_i[k] <= hist_i[k-1];
                hist_q[k] <= hist_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            d1_i <= '0;
            d1_q <= '0;
            m1_i <= '0;
            m1_q <= '0;
        end else begin
            v1 <= launch;
            if (launch) begin
                d1_i <= (W+1)'(hist_i[SPS-1]) - (W+1)'(x_i);
                d1_q <= (W+1)'(hist_q[SPS-1]) - (W+1)'(x_q);
                m1_i <= hist_i[SPS/2-1];
                m1_q <= hist_q[SPS/2-1];
            end
        end
    end

    always_comb begin
        prod_i = PW'(d1_i) * PW'(m1_i);
        prod_q = PW'(d1_q) * PW'(m1_q);
        prod   = (ModeIq != 0) ? prod_i + prod_q : prod_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            p2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) p2 <= prod;
        end
    end

    // Round half toward +inf, then clamp to the output range
    always_comb begin
        rnd   = (XW'(p2) + RND) >>> ShiftBits;
        clamp = 1'b0;
        res   = rnd[OL-1:0];
        if (rnd > SAT_MAX) begin
            res   = OUT_MAX;
            clamp = 1'b1;
        end else if (rnd < SAT_MIN) begin
            res   = OUT_MIN;
            clamp = 1'b1;
        end
    end

    assign ovr_evt = v2 & out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out           <= '0;
            out_valid     <= 1'b0;
            sat           <= 1'b0;
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else begin
            overrun <= ovr_evt;
            if (v2) begin
                out       <= res;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            sat <= (v2 & clamp) | (sat & ~clear);
            if (ovr_evt) begin
                if (clear)                        overrun_count <= 8'd1;
                else if (overrun_count != 8'hFF)  overrun_count <= overrun_count + 8'd1;
            end else if (clear) begin
                overrun_count <= '0;
            end
        end
    end

endmodule
